// File: rtl/vga_text_scroller.sv
// rtl/vga_text_scroller.sv - scaled 8x8 text line renderer, 2-stage pipeline
// Optional marquee scrolling is built when TEXT_SCROLL_EN is defined.
module vga_text_scroller #(
  parameter int NUM_CHARS  = 8,
  parameter int SCALE_LOG2 = 0,
  parameter int TEXT_X     = 64,
  parameter int TEXT_Y     = 100,
  parameter int V_ACTIVE   = 480,
  parameter int FRAME_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       scroll_en,
  input  logic [5:0] fg_color,
  input  logic [5:0] bg_color,
  output logic [5:0] rgb,
  output logic       hsync_o,
  output logic       vsync_o
);
  localparam int          WIN_W = NUM_CHARS * 8 * (1 << SCALE_LOG2);
  localparam int          WIN_H = 8 * (1 << SCALE_LOG2);
  localparam logic [11:0] X_LO  = 12'(TEXT_X);
  localparam logic [11:0] X_HI  = 12'(TEXT_X + WIN_W);
  localparam logic [11:0] Y_LO  = 12'(TEXT_Y);
  localparam logic [11:0] Y_HI  = 12'(TEXT_Y + WIN_H);
  localparam logic [11:0] W12   = 12'(WIN_W);
  localparam logic [4:0]  NC    = 5'(NUM_CHARS);

  logic [11:0] x12, y12, rel_x, rel_y, u_sum, u, u_slot, u_col, rel_y_s;
  logic [11:0] offset;
  logic        in_window;
  logic [3:0]  text_buf [16];

  logic       s1_in_win, s1_active, s1_hs, s1_vs;
  logic [2:0] s1_row, s1_col;
  logic [3:0] s1_code;
  logic [7:0] font_bits;
  logic       pix_on;

  function automatic logic [7:0] font_row(input logic [3:0] code, input logic [2:0] row);
    logic [63:0] g;
    case (code)
      4'd1:    g = 64'h8080_B0C8_8888_8800;
      4'd2:    g = 64'h0000_7880_7008_F000;
      4'd3:    g = 64'h7088_0830_0888_7000;
      4'd4:    g = 64'h0000_0000_0060_6000;
      4'd5:    g = 64'h0000_F088_88F0_8080;
      4'd6:    g = 64'h6020_2020_2020_7000;
      4'd7:    g = 64'h7088_98A8_C888_7000;
      4'd8:    g = 64'h2060_2020_2020_7000;
      4'd9:    g = 64'h7088_0810_2040_F800;
      4'd10:   g = 64'h1030_5090_F810_1000;
      4'd11:   g = 64'hF880_F008_0888_7000;
      4'd12:   g = 64'h3040_80F0_8888_7000;
      4'd13:   g = 64'hF808_1020_4040_4000;
      4'd14:   g = 64'h7088_8870_8888_7000;
      4'd15:   g = 64'h7088_8878_0810_6000;
      default: g = '0;
    endcase
    // Row 0 is the top byte, so bit offset is 8*(7-row).
    return g[{~row, 3'b000} +: 8];
  endfunction

  assign x12       = {2'b00, pix_x};
  assign y12       = {2'b00, pix_y};
  assign in_window = (x12 >= X_LO) && (x12 < X_HI) && (y12 >= Y_LO) && (y12 < Y_HI);
  assign rel_x     = x12 - X_LO;
  assign rel_y     = y12 - Y_LO;
  // rel_x and offset are both below WIN_W inside the window, so one subtract is a full modulo.
  assign u_sum     = rel_x + offset;
  assign u         = (u_sum >= W12) ? u_sum - W12 : u_sum;
  assign u_slot    = u >> (3 + SCALE_LOG2);
  assign u_col     = u >> SCALE_LOG2;
  assign rel_y_s   = rel_y >> SCALE_LOG2;

`ifdef TEXT_SCROLL_EN
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
  logic [7:0] div_cnt;
  logic       frame_tick;

  // Ticks at the first blanking line, so offset never moves mid-image.
  assign frame_tick = (pix_x == 10'd0) && (pix_y == 10'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      offset  <= '0;
    end else if (frame_tick && scroll_en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        offset  <= (offset == W12 - 12'd1) ? '0 : offset + 12'd1;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_scroll;
  assign offset        = '0;
  assign unused_scroll = scroll_en;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, u_slot[11:4], u_col[11:3], rel_y_s[11:3]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) text_buf[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < NC)) begin
      text_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_in_win <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_code   <= '0;
      s1_active <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else begin
      s1_in_win <= in_window;
      s1_row    <= rel_y_s[2:0];
      s1_col    <= u_col[2:0];
      s1_code   <= text_buf[u_slot[3:0]];
      s1_active <= video_active;
      s1_hs     <= hsync_i;
      s1_vs     <= vsync_i;
    end
  end

  assign font_bits = font_row(s1_code, s1_row);
  assign pix_on    = font_bits[~s1_col];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb     <= '0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      hsync_o <= s1_hs;
      vsync_o <= s1_vs;
      if (!s1_active)              rgb <= '0;
      else if (s1_in_win && pix_on) rgb <= fg_color;
      else                         rgb <= bg_color;
    end
  end

endmodule

// File: tb/tb_vga_text_scroller.sv
// tb/tb_vga_text_scroller.sv - directed self-checking bench for vga_text_scroller
module tb_vga_text_scroller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       video_active, hsync_i, vsync_i;
  logic       wr_en;
  logic [3:0] wr_addr, wr_data;
  logic       scroll_en;
  logic [5:0] fg_color, bg_color;
  logic [5:0] rgb0, rgb1;
  logic       hs0, vs0, hs1, vs1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_text_scroller #(.NUM_CHARS(8), .SCALE_LOG2(0), .TEXT_X(64), .TEXT_Y(100),
                      .V_ACTIVE(480), .FRAME_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .scroll_en(scroll_en),
    .fg_color(fg_color), .bg_color(bg_color), .rgb(rgb0), .hsync_o(hs0), .vsync_o(vs0));

  vga_text_scroller #(.NUM_CHARS(8), .SCALE_LOG2(1), .TEXT_X(64), .TEXT_Y(100),
                      .V_ACTIVE(480), .FRAME_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .scroll_en(scroll_en),
    .fg_color(fg_color), .bg_color(bg_color), .rgb(rgb1), .hsync_o(hs1), .vsync_o(vs1));

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y, input logic va);
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_active = va;
    tick();
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic frame();
    pix_x = 10'd0; pix_y = 10'd480; video_active = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1; video_active = 1'b1;
    pix_x = 10'd64; pix_y = 10'd102; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    scroll_en = 1'b0; fg_color = 6'h3F; bg_color = 6'h15;
    repeat (3) tick();
    chk("reset_rgb", rgb0, 6'h00);
    chk("reset_hsync", {5'b0, hs0}, 6'h00);
    chk("reset_vsync", {5'b0, vs0}, 6'h00);
    rst_n = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;

    wr(4'd0, 4'd1);
    wr(4'd3, 4'd1);
    probe(64, 102, 1'b1);  chk("h_col0", rgb0, 6'h3F);
    probe(65, 102, 1'b1);  chk("h_col1", rgb0, 6'h15);
    probe(64, 102, 1'b0);  chk("blank", rgb0, 6'h00);
    probe(66, 102, 1'b1);  chk("h_col2", rgb0, 6'h3F);
    probe(68, 102, 1'b1);  chk("h_col4", rgb0, 6'h15);
    probe(63, 102, 1'b1);  chk("left_out", rgb0, 6'h15);
    probe(64, 108, 1'b1);  chk("below_out", rgb0, 6'h15);
    probe(64, 107, 1'b1);  chk("h_row7", rgb0, 6'h15);
    probe(88, 102, 1'b1);  chk("slot3", rgb0, 6'h3F);

    probe(64, 104, 1'b1);  chk("s1_x0y4", rgb1, 6'h3F);
    probe(65, 105, 1'b1);  chk("s1_x1y5", rgb1, 6'h3F);
    probe(66, 104, 1'b1);  chk("s1_x2y4", rgb1, 6'h15);

    pix_x = 10'd64; pix_y = 10'd102; hsync_i = 1'b1; vsync_i = 1'b1;
    tick();
    chk("hs_d1", {5'b0, hs0}, 6'h00);
    pix_x = 10'd65; hsync_i = 1'b0; vsync_i = 1'b0;
    tick();
    chk("hs_d2", {5'b0, hs0}, 6'h01);
    chk("vs_d2", {5'b0, vs0}, 6'h01);
    chk("hs_rgb_a", rgb0, 6'h3F);
    tick();
    chk("hs_d3", {5'b0, hs0}, 6'h00);
    chk("hs_rgb_b", rgb0, 6'h15);

    wr(4'd8, 4'd2);
    probe(64, 102, 1'b1);  chk("wr_ignored", rgb0, 6'h3F);

    pix_x = 10'd64; pix_y = 10'd102; video_active = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd0;
    tick();
    wr_en = 1'b0;
    tick();
    chk("wr_old", rgb0, 6'h3F);
    tick();
    chk("wr_new", rgb0, 6'h15);
    wr(4'd0, 4'd1);

`ifdef TEXT_SCROLL_EN
    scroll_en = 1'b1;
    probe(64, 102, 1'b1);  chk("off0_a", rgb0, 6'h3F);
    probe(65, 102, 1'b1);  chk("off0_b", rgb0, 6'h15);
    frame();
    probe(64, 102, 1'b1);  chk("t1_a", rgb0, 6'h3F);
    frame();
    probe(64, 102, 1'b1);  chk("t2_a", rgb0, 6'h15);
    probe(65, 102, 1'b1);  chk("t2_b", rgb0, 6'h3F);
    frame();
    probe(64, 102, 1'b1);  chk("t3_a", rgb0, 6'h15);
    frame();
    probe(64, 102, 1'b1);  chk("t4_a", rgb0, 6'h3F);
    probe(65, 102, 1'b1);  chk("t4_b", rgb0, 6'h3F);
    repeat (122) frame();
    probe(64, 102, 1'b1);  chk("w63_a", rgb0, 6'h15);
    probe(65, 102, 1'b1);  chk("w63_b", rgb0, 6'h3F);
    repeat (2) frame();
    probe(64, 102, 1'b1);  chk("wrap_a", rgb0, 6'h3F);
    probe(65, 102, 1'b1);  chk("wrap_b", rgb0, 6'h15);
    scroll_en = 1'b0;
    repeat (3) frame();
    probe(64, 102, 1'b1);  chk("hold_a", rgb0, 6'h3F);
    probe(65, 102, 1'b1);  chk("hold_b", rgb0, 6'h15);
`else
    scroll_en = 1'b1;
    repeat (3) frame();
    probe(64, 102, 1'b1);  chk("static_a", rgb0, 6'h3F);
    probe(65, 102, 1'b1);  chk("static_b", rgb0, 6'h15);
    scroll_en = 1'b0;
`endif

    scroll_en = 1'b1;
    repeat (2) frame();
    scroll_en = 1'b0;
    hsync_i = 1'b1;
    probe(64, 102, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_rgb", rgb0, 6'h00);
    chk("mid_rst_hs", {5'b0, hs0}, 6'h00);
    rst_n = 1'b1; hsync_i = 1'b0;
    tick();
    chk("rel_d1_rgb", rgb0, 6'h00);
    chk("rel_d1_hs", {5'b0, hs0}, 6'h00);
    tick();
    chk("rel_d2_bg", rgb0, 6'h15);
    probe(88, 102, 1'b1);  chk("slot3_clr", rgb0, 6'h15);
    wr(4'd0, 4'd1);
    probe(64, 102, 1'b1);  chk("rst_off_a", rgb0, 6'h3F);
    probe(65, 102, 1'b1);  chk("rst_off_b", rgb0, 6'h15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_text_scroller.md
# vga_text_scroller

Parametrised text renderer that sits between `hvsync_generator` and the TinyVGA output mapping. It draws a writable line of `NUM_CHARS` 8x8 glyphs, integer-scaled by 2^`SCALE_LOG2`, inside a fixed window, with optional horizontal marquee scrolling. Output is a 2-stage registered pipeline, with hsync and vsync delayed to match.

## Interface
Parameters:
- `NUM_CHARS`, 8: text buffer depth in characters (1..16).
- `SCALE_LOG2`, 0: glyph scale, where each font pixel is 2^S x 2^S screen pixels (0..3).
- `TEXT_X`, 64: window left edge in pixels.
- `TEXT_Y`, 100: window top edge in pixels.
- `V_ACTIVE`, 480: number of visible lines; the frame tick is derived from it.
- `FRAME_DIV`, 1: frames per 1-pixel scroll step (1..255).

Ports:
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `pix_x`, in, 10: horizontal position from hvsync_generator.
- `pix_y`, in, 10: vertical position from hvsync_generator.
- `video_active`, in, 1: display_on.
- `hsync_i`, in, 1: raw hsync.
- `vsync_i`, in, 1: raw vsync.
- `wr_en`, in, 1: text buffer write strobe.
- `wr_addr`, in, 4: character slot.
- `wr_data`, in, 4: glyph code.
- `scroll_en`, in, 1: scrolling runs when 1, freezes when 0.
- `fg_color`, in, 6: {R[1:0],G[1:0],B[1:0]} for text.
- `bg_color`, in, 6: colour for the window and the rest of the active area.
- `rgb`, out, 6: registered {R,G,B}.
- `hsync_o`, out, 1: hsync_i delayed by 2 cycles.
- `vsync_o`, out, 1: vsync_i delayed by 2 cycles.

## Operation
- Window: width W = NUM_CHARS·8·2^S, height H = 8·2^S. A pixel is inside when TEXT_X ≤ pix_x < TEXT_X+W and TEXT_Y ≤ pix_y < TEXT_Y+H.
- Scrolled coordinate: u = (pix_x − TEXT_X + offset) mod W. Char slot = u >> (3+S). Column = (u >> S) & 7. Row = ((pix_y − TEXT_Y) >> S) & 7. Font bit = row byte bit [7−column], MSB leftmost.
- Glyph codes: 0 space, 1 'h', 2 's', 3 '3', 4 '.', 5 'p', 6 'l', 7..15 '0','1','2','4','5','6','7','8','9'. Unused codes render blank. 'h' rows are 80,80,B0,C8,88,88,88,00. 's' rows are 00,00,78,80,70,08,F0,00.
- Colour: !video_active gives 0. Inside the window with the font bit set gives fg_color. Everything else gives bg_color.
- Text buffer: NUM_CHARS×4 bit registers. A write with wr_en=1 and wr_addr < NUM_CHARS updates the slot at the clock edge. Writes with wr_addr ≥ NUM_CHARS are ignored.
- Scroll state:
  - frame_tick fires for one cycle when pix_x==0 && pix_y==V_ACTIVE.
  - div_cnt (8 bit) increments on every frame_tick while scroll_en=1.
  - When div_cnt reaches FRAME_DIV−1, div_cnt returns to 0 and offset advances by 1.
  - offset wraps from W−1 to 0.
  - scroll_en=0 holds both div_cnt and offset.

## Timing
- Stage 1 registers in_window, row, column, the buffer glyph code, video_active and the syncs. Stage 2 performs the font lookup and colour select into `rgb`.
- Latency is 2 clocks from pix_x/pix_y to rgb. hsync_o and vsync_o carry the same 2-clock delay.
- A write at edge N is visible to a stage-1 read at edge N+1; a read at edge N sees the old value. Write-while-render is legal, and a mid-frame write may tear.
- Offset changes only during vertical blanking, so the image never tears from scrolling.
- Reset (rst_n=0 at an edge) sets the following, with priority over all other activity including mid-frame:
  - rgb=0, hsync_o=0, vsync_o=0
  - both pipeline stages cleared
  - all buffer slots = 0 (space)
  - offset = 0, div_cnt = 0
- Output resumes 2 cycles after release.

## Configuration
- `TEXT_SCROLL_EN` defined: offset and div_cnt exist and behave as described above.
- `TEXT_SCROLL_EN` undefined: offset is the constant 0, no counters are synthesised, and scroll_en is ignored. The result is static left-aligned text.

## Test plan
- Reset, then write slot0=1 ('h'), S=0, scroll_en=0, fg=3F, bg=15. At pixel (TEXT_X, TEXT_Y+2) rgb=3F two cycles later; at (TEXT_X+1, TEXT_Y+2) rgb=15; with video_active=0, rgb=00.
- Scale: S=1, slot0='h'. Pixels (TEXT_X+0..1, TEXT_Y+4..5) are all fg and (TEXT_X+2, TEXT_Y+4) is bg.
- Scroll: FRAME_DIV=2, scroll_en=1. offset=0,0,1,1,2 after frame ticks 0..4. Preset offset=W−1, then one step gives offset=0 (wrap). scroll_en=0 for 3 frames leaves offset unchanged.
- Writes: wr_addr=NUM_CHARS is ignored (buffer unchanged). A write on the same cycle as a read of that slot returns the old code, and the following cycle returns the new code.
- Pipeline: a hsync_i pulse appears on hsync_o exactly 2 cycles later, aligned with rgb of the same pix_x.
- Mid-frame reset: assert rst_n=0 for 1 cycle during the text window. Next cycle rgb=0, all slots read 0, offset=0. After release, bg-only output follows 2 cycles later.
